// File: rtl/host_pkg.sv
// Shared types and default widths for the host-side core sequencer.
package host_pkg;

  localparam int AW_DEF = 8;
  localparam int TW_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_CORE_RST = 3'd2,
    ST_RUN      = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_DONE     = 3'd5
  } host_state_e;

endpackage

// File: rtl/host_cycle_ctr.sv
// Cycle counter with clear/enable; expire flags the last cycle of a limit-long window.
module host_cycle_ctr #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [TW-1:0] limit,
  output logic          expire
);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A zero limit never expires.
  assign expire = (limit != '0) && (count_q == (limit - TW'(1)));

endmodule

// File: rtl/core_host_seq.sv
// Host sequencer: loads operands into data memory, runs the core via req/done,
// then drains result bytes over a valid/ready port.
module core_host_seq
  import host_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int TW      = TW_DEF,
  parameter int RST_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] ld_count,
  input  logic [AW-1:0] rd_base,
  input  logic [AW-1:0] rd_count,
  input  logic [TW-1:0] timeout,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          mem_own,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wr_dat,
  input  logic [7:0]    mem_rd_dat,
  output logic          res_valid,
  output logic [7:0]    res_data,
  input  logic          res_ready,
  output logic          busy,
  output logic          finished,
  output logic          err_timeout,
  output host_state_e   dbg_state
);

  // Handshakes: a byte moves on a cycle where valid && ready at the rising edge;
  // valid and data hold until accepted, ready may toggle freely.

  host_state_e   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] ld_count_q, ld_count_d;
  logic [AW-1:0] rd_base_q, rd_base_d;
  logic [AW-1:0] rd_count_q, rd_count_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic          err_q, err_d;

  logic          ctr_clr;
  logic          ctr_en;
  logic [TW-1:0] ctr_limit;
  logic          ctr_expire;

  // One counter serves both CORE_RST and RUN; any state change restarts it.
  assign ctr_clr   = (state_d != state_q);
  assign ctr_en    = (state_q == ST_CORE_RST) || (state_q == ST_RUN);
  assign ctr_limit = (state_q == ST_CORE_RST) ? TW'(RST_CYC) : timeout_q;

  host_cycle_ctr #(.TW(TW)) u_cycle_ctr (
    .clk    (clk),
    .reset  (reset),
    .clr    (ctr_clr),
    .en     (ctr_en),
    .limit  (ctr_limit),
    .expire (ctr_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      ld_count_q <= '0;
      rd_base_q  <= '0;
      rd_count_q <= '0;
      timeout_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ld_count_q <= ld_count_d;
      rd_base_q  <= rd_base_d;
      rd_count_q <= rd_count_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ld_count_d = ld_count_q;
    rd_base_d  = rd_base_q;
    rd_count_d = rd_count_q;
    timeout_d  = timeout_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ld_count_d = ld_count;
          rd_base_d  = rd_base;
          rd_count_d = rd_count;
          timeout_d  = timeout;
          err_d      = 1'b0;
          addr_d     = '0;
          state_d    = (ld_count == '0) ? ST_CORE_RST : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          addr_d = addr_q + AW'(1);
          if (addr_q == (ld_count_q - AW'(1))) begin
            state_d = ST_CORE_RST;
          end
        end
      end
      ST_CORE_RST: begin
        if (ctr_expire) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // done takes priority over a timeout landing in the same cycle
        if (core_done) begin
          addr_d  = rd_base_q;
          state_d = (rd_count_q == '0) ? ST_DONE : ST_DRAIN;
        end else if (ctr_expire) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (res_ready) begin
          addr_d = addr_q + AW'(1);
          if ((addr_q - rd_base_q) == (rd_count_q - AW'(1))) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ld_ready    = (state_q == ST_LOAD);
    mem_wr_en   = (state_q == ST_LOAD) && ld_valid;
    mem_wr_dat  = mem_wr_en ? ld_data : 8'h00;
    mem_own     = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    mem_addr    = mem_own ? addr_q : '0;
    res_valid   = (state_q == ST_DRAIN);
    res_data    = res_valid ? mem_rd_dat : 8'h00;
    core_reset  = (state_q != ST_RUN);
    core_req    = (state_q == ST_RUN);
    busy        = (state_q != ST_IDLE);
    finished    = (state_q == ST_DONE);
    err_timeout = err_q;
    dbg_state   = state_q;
  end

endmodule
